// File: rtl/mesi_isc_mbus_arb_if.sv
// Main-bus / coherence-bus signal bundle between four CPUs and the MESI
// main-bus arbiter. CPU n owns lane n of each packed per-CPU vector.
interface mesi_isc_mbus_arb_if #(
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32
);
    logic [4*MBUS_CMD_WIDTH-1:0] mbus_cmd_i;
    logic [4*ADDR_WIDTH-1:0]     mbus_addr_i;
    logic [3:0]                  cbus_ack_i;
    logic [4*CBUS_CMD_WIDTH-1:0] cbus_cmd_o;
    logic [ADDR_WIDTH-1:0]       cbus_addr_o;
    logic [3:0]                  mbus_ack_o;
    logic                        busy_o;

    modport master (
        output mbus_cmd_i, mbus_addr_i, cbus_ack_i,
        input  cbus_cmd_o, cbus_addr_o, mbus_ack_o, busy_o
    );

    modport slave (
        input  mbus_cmd_i, mbus_addr_i, cbus_ack_i,
        output cbus_cmd_o, cbus_addr_o, mbus_ack_o, busy_o
    );
endinterface

// File: rtl/mesi_isc_mbus_arb.sv
// Round-robin main-bus arbiter: grants one broadcast request at a time, snoops
// the other three CPUs, enables the owner, then acknowledges completion.
module mesi_isc_mbus_arb #(
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32
) (
    input logic                 clk,
    input logic                 rst,
    mesi_isc_mbus_arb_if.slave  bus
);
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR_BROAD = MBUS_CMD_WIDTH'(3);
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD_BROAD = MBUS_CMD_WIDTH'(4);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_NOP      = CBUS_CMD_WIDTH'(0);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_RD    = CBUS_CMD_WIDTH'(4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SNOOP  = 2'd1,
        ENABLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  rr_ptr_q, rr_ptr_d;
    logic [1:0]                  gnt_q, gnt_d;
    logic [3:0]                  sticky_q, sticky_d;
    logic [MBUS_CMD_WIDTH-1:0]   cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [4*CBUS_CMD_WIDTH-1:0] cbus_cmd_q, cbus_cmd_d;
    logic [ADDR_WIDTH-1:0]       cbus_addr_q, cbus_addr_d;
    logic [3:0]                  mbus_ack_q, mbus_ack_d;
    logic                        busy_q, busy_d;

    logic [MBUS_CMD_WIDTH-1:0]   lane_cmd_s [4];
    logic [ADDR_WIDTH-1:0]       lane_addr_s [4];
    logic [3:0]                  req_s;
    logic [3:0]                  gnt_oh_s;
    logic [3:0]                  gnt_oh_d_s;
    logic [1:0]                  pick_s;
    logic                        found_s;
    logic [CBUS_CMD_WIDTH-1:0]   snp_code_s;
    logic [CBUS_CMD_WIDTH-1:0]   en_code_s;

    // Unpack per-CPU lanes and flag broadcast requests
    always_comb begin
        req_s = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            lane_cmd_s[n]  = bus.mbus_cmd_i[n*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
            lane_addr_s[n] = bus.mbus_addr_i[n*ADDR_WIDTH +: ADDR_WIDTH];
            req_s[n]       = (lane_cmd_s[n] == MBUS_WR_BROAD) ||
                             (lane_cmd_s[n] == MBUS_RD_BROAD);
        end
    end

    // Round-robin search for the first requester at or after rr_ptr
    always_comb begin
        logic [1:0] idx;
        pick_s  = 2'd0;
        found_s = 1'b0;
        idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!found_s && req_s[idx]) begin
                found_s = 1'b1;
                pick_s  = idx;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign gnt_oh_s = 4'b0001 << gnt_q;

    // Next-state logic for the transaction FSM and its latched context
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        sticky_d = sticky_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d  = SNOOP;
                    gnt_d    = pick_s;
                    rr_ptr_d = pick_s + 2'd1;
                    cmd_d    = lane_cmd_s[pick_s];
                    addr_d   = lane_addr_s[pick_s];
                    sticky_d = 4'b0000;
                end else begin
                    state_d = IDLE;
                end
            end
            SNOOP: begin
                // The owner's own ack is masked: it is not being snooped
                sticky_d = sticky_q | (bus.cbus_ack_i & ~gnt_oh_s);
                if ((sticky_d | gnt_oh_s) == 4'b1111) begin
                    state_d = ENABLE;
                end else begin
                    state_d = SNOOP;
                end
            end
            ENABLE: begin
                if (bus.cbus_ack_i[gnt_q]) begin
                    state_d = RESP;
                end else begin
                    state_d = ENABLE;
                end
            end
            RESP: begin
                state_d  = IDLE;
                cmd_d    = {MBUS_CMD_WIDTH{1'b0}};
                addr_d   = {ADDR_WIDTH{1'b0}};
                sticky_d = 4'b0000;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_oh_d_s = 4'b0001 << gnt_d;
    assign snp_code_s = (cmd_d == MBUS_WR_BROAD) ? CBUS_WR_SNOOP : CBUS_RD_SNOOP;
    assign en_code_s  = (cmd_d == MBUS_WR_BROAD) ? CBUS_EN_WR : CBUS_EN_RD;

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        cbus_cmd_d  = {4*CBUS_CMD_WIDTH{1'b0}};
        busy_d      = (state_d != IDLE);
        cbus_addr_d = busy_d ? addr_d : {ADDR_WIDTH{1'b0}};
        mbus_ack_d  = (state_d == RESP) ? gnt_oh_d_s : 4'b0000;
        for (int n = 0; n < 4; n++) begin
            case (state_d)
                SNOOP: begin
                    if (!gnt_oh_d_s[n] && !sticky_d[n]) begin
                        cbus_cmd_d[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = snp_code_s;
                    end else begin
                        cbus_cmd_d[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = CBUS_NOP;
                    end
                end
                ENABLE: begin
                    if (gnt_oh_d_s[n]) begin
                        cbus_cmd_d[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = en_code_s;
                    end else begin
                        cbus_cmd_d[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = CBUS_NOP;
                    end
                end
                default: begin
                    cbus_cmd_d[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = CBUS_NOP;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 2'd0;
            gnt_q       <= 2'd0;
            sticky_q    <= 4'b0000;
            cmd_q       <= {MBUS_CMD_WIDTH{1'b0}};
            addr_q      <= {ADDR_WIDTH{1'b0}};
            cbus_cmd_q  <= {4*CBUS_CMD_WIDTH{1'b0}};
            cbus_addr_q <= {ADDR_WIDTH{1'b0}};
            mbus_ack_q  <= 4'b0000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            sticky_q    <= sticky_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            cbus_cmd_q  <= cbus_cmd_d;
            cbus_addr_q <= cbus_addr_d;
            mbus_ack_q  <= mbus_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cbus_cmd_o  = cbus_cmd_q;
    assign bus.cbus_addr_o = cbus_addr_q;
    assign bus.mbus_ack_o  = mbus_ack_q;
    assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_mesi_isc_mbus_arb.sv
// Bench for the main-bus arbiter: directed vector table, hand-written corner
// sequences, and random traffic against a transaction-level reference model.
module tb_mesi_isc_mbus_arb;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    mesi_isc_mbus_arb_if bus ();

    mesi_isc_mbus_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [11:0]  cmd;
        logic [127:0] addr;
        logic [3:0]   ack;
        logic [11:0]  e_cbus;
        logic [31:0]  e_addr;
        logic [3:0]   e_mack;
        logic         e_busy;
    } vec_t;

    vec_t vt [12];

    // Reference model: one in-flight transaction described by owner and stage
    int           r_cmd [4];
    logic [31:0]  r_addr [4];
    bit   [3:0]   r_ack;
    bit           m_busy;
    int           m_owner;
    int           m_stage;
    int           m_ptr;
    bit           m_wr;
    logic [31:0]  m_addr;
    bit   [3:0]   m_pend;
    logic [11:0]  e_cbus;
    logic [31:0]  e_addr;
    logic [3:0]   e_mack;
    logic         e_busy;

    function automatic logic [11:0] pk3(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic logic [127:0] pka(input logic [31:0] a0, input logic [31:0] a1,
                                         input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [11:0] ec, input logic [31:0] ea,
                            input logic [3:0] em, input logic eb);
        chk({nm, "_cbus_cmd"}, 128'(bus.cbus_cmd_o), 128'(ec));
        chk({nm, "_cbus_addr"}, 128'(bus.cbus_addr_o), 128'(ea));
        chk({nm, "_mbus_ack"}, 128'(bus.mbus_ack_o), 128'(em));
        chk({nm, "_busy"}, 128'(bus.busy_o), 128'(eb));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.mbus_cmd_i  = 12'h0;
        bus.mbus_addr_i = 128'h0;
        bus.cbus_ack_i  = 4'h0;
        @(negedge clk);
        chk_outs("reset", 12'h0, 32'h0, 4'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_ptr  = 0;
        m_pend = 4'h0;
    endtask

    // Advance the model by one clock using the inputs about to be sampled
    task automatic model_step();
        if (!m_busy) begin
            for (int i = 0; i < 4; i++) begin
                int c;
                c = (m_ptr + i) % 4;
                if (!m_busy && (r_cmd[c] == 3 || r_cmd[c] == 4)) begin
                    m_busy  = 1'b1;
                    m_owner = c;
                    m_wr    = (r_cmd[c] == 3);
                    m_addr  = r_addr[c];
                    m_stage = 1;
                    m_pend  = 4'hF & ~(4'b0001 << c);
                    m_ptr   = (c + 1) % 4;
                end
            end
        end else if (m_stage == 1) begin
            m_pend = m_pend & ~r_ack;
            if (m_pend == 4'h0) m_stage = 2;
        end else if (m_stage == 2) begin
            if (r_ack[m_owner]) m_stage = 3;
        end else begin
            m_busy = 1'b0;
        end
        e_cbus = 12'h0;
        e_addr = 32'h0;
        e_mack = 4'h0;
        e_busy = 1'b0;
        if (m_busy) begin
            e_busy = 1'b1;
            e_addr = m_addr;
            if (m_stage == 1) begin
                for (int k = 0; k < 4; k++)
                    if (m_pend[k]) e_cbus[3*k +: 3] = m_wr ? 3'd1 : 3'd2;
            end else if (m_stage == 2) begin
                e_cbus[3*m_owner +: 3] = m_wr ? 3'd3 : 3'd4;
            end else begin
                e_mack[m_owner] = 1'b1;
            end
        end
    endtask

    initial begin
        int nacks;
        int owner;
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        bus.mbus_cmd_i  = 12'h0;
        bus.mbus_addr_i = 128'h0;
        bus.cbus_ack_i  = 4'h0;

        // RD_BROAD from CPU1, non-requests, then WR_BROAD from CPU0 with a spurious ack
        vt[0]  = '{pk3(0,4,0,0), pka(0,32'h100,0,0), 4'b0000, pk3(2,0,2,2), 32'h100, 4'b0000, 1'b1};
        vt[1]  = '{pk3(0,4,0,0), pka(0,32'h999,0,0), 4'b1101, pk3(0,4,0,0), 32'h100, 4'b0000, 1'b1};
        vt[2]  = '{pk3(0,4,0,0), pka(0,32'h999,0,0), 4'b0010, pk3(0,0,0,0), 32'h100, 4'b0010, 1'b1};
        vt[3]  = '{pk3(0,0,0,0), pka(0,0,0,0),       4'b0000, pk3(0,0,0,0), 32'h0,   4'b0000, 1'b0};
        vt[4]  = '{pk3(0,0,5,1), pka(1,2,3,4),       4'b1111, pk3(0,0,0,0), 32'h0,   4'b0000, 1'b0};
        vt[5]  = '{pk3(0,0,5,1), pka(1,2,3,4),       4'b1111, pk3(0,0,0,0), 32'h0,   4'b0000, 1'b0};
        vt[6]  = '{pk3(3,0,0,0), pka(32'hABC,1,2,3), 4'b0000, pk3(0,1,1,1), 32'hABC, 4'b0000, 1'b1};
        vt[7]  = '{pk3(3,0,0,0), pka(32'hABC,1,2,3), 4'b1110, pk3(3,0,0,0), 32'hABC, 4'b0000, 1'b1};
        vt[8]  = '{pk3(3,0,0,0), pka(32'hABC,1,2,3), 4'b0010, pk3(3,0,0,0), 32'hABC, 4'b0000, 1'b1};
        vt[9]  = '{pk3(3,0,0,0), pka(32'hABC,1,2,3), 4'b0010, pk3(3,0,0,0), 32'hABC, 4'b0000, 1'b1};
        vt[10] = '{pk3(3,0,0,0), pka(32'hABC,1,2,3), 4'b0001, pk3(0,0,0,0), 32'hABC, 4'b0001, 1'b1};
        vt[11] = '{pk3(0,0,0,0), pka(0,0,0,0),       4'b0000, pk3(0,0,0,0), 32'h0,   4'b0000, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.mbus_cmd_i  = vt[i].cmd;
            bus.mbus_addr_i = vt[i].addr;
            bus.cbus_ack_i  = vt[i].ack;
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vt[i].e_cbus, vt[i].e_addr, vt[i].e_mack, vt[i].e_busy);
        end

        // Late snoop ack from CPU2 stretches SNOOP to six cycles
        do_reset();
        bus.mbus_cmd_i  = pk3(3,0,0,0);
        bus.mbus_addr_i = pka(32'h40,0,0,0);
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            chk($sformatf("late_snoop%0d", s), 128'(bus.cbus_cmd_o),
                128'((s == 0) ? pk3(0,1,1,1) : pk3(0,0,1,0)));
            bus.cbus_ack_i = (s == 0) ? 4'b1010 : ((s == 5) ? 4'b0100 : 4'b0000);
        end
        @(negedge clk);
        chk("late_enable", 128'(bus.cbus_cmd_o), 128'(pk3(3,0,0,0)));
        bus.cbus_ack_i = 4'b0001;
        @(negedge clk);
        chk("late_resp", 128'(bus.mbus_ack_o), 128'(4'b0001));
        bus.mbus_cmd_i = 12'h0;
        bus.cbus_ack_i = 4'b0000;

        // Reset during ENABLE of CPU2 aborts the transaction and rewinds rr_ptr
        do_reset();
        bus.mbus_cmd_i = pk3(0,0,3,0);
        @(negedge clk);
        chk("abort_snoop", 128'(bus.cbus_cmd_o), 128'(pk3(1,1,0,1)));
        bus.cbus_ack_i = 4'b1011;
        @(negedge clk);
        chk("abort_enable", 128'(bus.cbus_cmd_o), 128'(pk3(0,0,3,0)));
        bus.cbus_ack_i = 4'b0100;
        bus.mbus_cmd_i = pk3(0,3,3,3);
        #2 rst = 1'b1;
        #1 chk_outs("abort_async", 12'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk_outs("abort_hold", 12'h0, 32'h0, 4'h0, 1'b0);
        rst = 1'b0;
        bus.cbus_ack_i = 4'b0000;
        @(negedge clk);
        chk("abort_regrant", 128'(bus.cbus_cmd_o), 128'(pk3(1,0,1,1)));
        bus.mbus_cmd_i = 12'h0;

        // All CPUs request continuously: grants rotate 0,1,2,3,0
        do_reset();
        bus.mbus_cmd_i = pk3(3,3,3,3);
        bus.cbus_ack_i = 4'b1111;
        nacks = 0;
        for (int cyc = 0; cyc < 80 && nacks < 5; cyc++) begin
            @(negedge clk);
            if (bus.mbus_ack_o != 4'b0000) begin
                owner = -1;
                for (int k = 0; k < 4; k++) if (bus.mbus_ack_o[k]) owner = k;
                chk($sformatf("rr_onehot%0d", nacks), 128'($countones(bus.mbus_ack_o)), 128'(1));
                chk($sformatf("rr_order%0d", nacks), 128'(owner), 128'(nacks % 4));
                nacks++;
            end
        end
        chk("rr_ack_count", 128'(nacks), 128'(5));

        // Random traffic against the reference model
        do_reset();
        model_reset();
        for (int k = 0; k < 4; k++) begin
            r_cmd[k]  = 0;
            r_addr[k] = 32'h0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    int r;
                    r = int'($urandom_range(0, 9));
                    r_cmd[k] = (r <= 2) ? 3 : ((r <= 5) ? 4 : int'($urandom_range(0, 7)));
                end
                r_addr[k] = $urandom;
                bus.mbus_cmd_i[3*k +: 3]    = 3'(r_cmd[k]);
                bus.mbus_addr_i[32*k +: 32] = r_addr[k];
            end
            r_ack = 4'($urandom_range(0, 15));
            bus.cbus_ack_i = r_ack;
            model_step();
            @(negedge clk);
            chk_outs($sformatf("rnd%0d", cyc), e_cbus, e_addr, e_mack, e_busy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
